// File: rtl/quad_encoder_gen_pkg.sv
// Shared encodings for the quadrature encoder generator.
package quad_encoder_gen_pkg;

    localparam logic [1:0] DIR_CW   = 2'b10;
    localparam logic [1:0] DIR_CCW  = 2'b01;
    localparam logic [1:0] DIR_NONE = 2'b00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic dir_moves(input logic [1:0] dir);
        return (dir == DIR_CW) || (dir == DIR_CCW);
    endfunction

endpackage

// File: rtl/quad_encoder_gen_phase_step.sv
// Combinational next-phase function for the quadrature {A,B} pair.
module quad_phase_step
    import quad_encoder_gen_pkg::*;
(
    input  logic [1:0] phase,
    input  logic [1:0] dir,
    output logic [1:0] phase_next
);

    always_comb begin
        phase_next = phase;
        if (dir == DIR_CW) begin
            unique case (phase)
                2'b00: phase_next = 2'b01;
                2'b01: phase_next = 2'b11;
                2'b11: phase_next = 2'b10;
                2'b10: phase_next = 2'b00;
            endcase
        end else if (dir == DIR_CCW) begin
            unique case (phase)
                2'b00: phase_next = 2'b10;
                2'b10: phase_next = 2'b11;
                2'b11: phase_next = 2'b01;
                2'b01: phase_next = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder pattern generator: emits N edges at a fixed period in a
// commanded direction and tracks a signed position.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    output logic              A,
    output logic              B,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] position
);

    state_t              state_q, state_d;
    logic [1:0]          ab_q, ab_next;
    logic [1:0]          dir_q;
    logic [STEP_W-1:0]   pos_q;
    logic [STEP_W-1:0]   rem_q;
    logic [DIV_W-1:0]    presc_q;
    logic [DIV_W-1:0]    reload_q;
    logic [DIV_W-1:0]    cmd_reload;
    logic                done_q, done_d;
    logic                armed_q;
    logic                accept;
    logic                step_fire;

    quad_phase_step u_phase_step (
        .phase      (ab_q),
        .dir        (dir_q),
        .phase_next (ab_next)
    );

    // Prescaler counts down from period-1; a zero period is treated as one.
    assign cmd_reload = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        step_fire = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && armed_q) begin
                    accept = 1'b1;
                    if ((cmd_steps != '0) && dir_moves(cmd_dir))
                        state_d = ST_RUN;
                    else
                        done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (presc_q == '0) begin
                    step_fire = 1'b1;
                    if (rem_q == STEP_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ab_q     <= '0;
            dir_q    <= DIR_NONE;
            pos_q    <= '0;
            rem_q    <= '0;
            presc_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            armed_q <= 1'b1;
            if (accept) begin
                dir_q    <= cmd_dir;
                rem_q    <= cmd_steps;
                presc_q  <= cmd_reload;
                reload_q <= cmd_reload;
            end else if (state_q == ST_RUN && !abort) begin
                if (step_fire) begin
                    ab_q    <= ab_next;
                    pos_q   <= (dir_q == DIR_CW) ? pos_q + STEP_W'(1) : pos_q - STEP_W'(1);
                    rem_q   <= rem_q - STEP_W'(1);
                    presc_q <= reload_q;
                end else begin
                    presc_q <= presc_q - DIV_W'(1);
                end
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: cycle reference model with an
// expected-snapshot queue, plus hard-coded scenario checks.
module tb_quad_encoder_gen;

    localparam logic [1:0] CW   = 2'b10;
    localparam logic [1:0] CCW  = 2'b01;
    localparam logic [1:0] BAD  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_dir = 2'b00;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        A, B, busy, done;
    logic [15:0] position;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  ab;
        logic [15:0] pos;
        logic        busy;
        logic        done;
        logic        ready;
    } snap_t;

    snap_t exp_q[$];

    // reference model state
    logic        m_run, m_done, m_armed;
    logic [1:0]  m_ab, m_dir;
    logic [15:0] m_pos, m_rem, m_cnt, m_eff;

    // most recent observation
    logic [1:0]  obs_ab;
    logic [15:0] obs_pos;
    logic        obs_busy, obs_done;

    quad_encoder_gen #(.STEP_W(16), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .A(A), .B(B), .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model_next(input logic [1:0] ph, input logic [1:0] d);
        logic [1:0] seq [4];
        int unsigned idx;
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        idx = 0;
        for (int unsigned i = 0; i < 4; i++) if (seq[i] == ph) idx = i;
        if (d == CW)  return seq[(idx + 1) % 4];
        if (d == CCW) return seq[(idx + 3) % 4];
        return ph;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_armed = 0; m_ab = 2'b00; m_dir = 2'b00;
        m_pos = '0; m_rem = '0; m_cnt = '0; m_eff = 16'd1;
    endtask

    // One clock: drive inputs, predict the post-edge state, then sample and compare.
    task automatic cycle(input logic v, input logic [1:0] d, input logic [15:0] s,
                         input logic [15:0] p, input logic ab);
        snap_t e;
        logic  nd;
        cmd_valid = v; cmd_dir = d; cmd_steps = s; cmd_period = p; abort = ab;
        nd = 0;
        if (m_run) begin
            if (ab) m_run = 0;
            else if (m_cnt == 0) begin
                m_ab  = model_next(m_ab, m_dir);
                m_pos = (m_dir == CW) ? m_pos + 16'd1 : m_pos - 16'd1;
                m_rem = m_rem - 16'd1;
                m_cnt = m_eff - 16'd1;
                if (m_rem == 0) begin m_run = 0; nd = 1; end
            end else m_cnt = m_cnt - 16'd1;
        end else if (v && m_armed) begin
            m_dir = d; m_rem = s; m_eff = (p == 0) ? 16'd1 : p; m_cnt = m_eff - 16'd1;
            if (s != 0 && (d == CW || d == CCW)) m_run = 1; else nd = 1;
        end
        m_done = nd; m_armed = 1;
        exp_q.push_back('{ab: m_ab, pos: m_pos, busy: m_run, done: m_done, ready: !m_run});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        obs_ab = {A, B}; obs_pos = position; obs_busy = busy; obs_done = done;
        n_checks++;
        if ({A, B} !== e.ab) begin
            n_fail++; $display("FAIL sb_ab t=%0t got %b want %b", $time, {A, B}, e.ab);
        end
        n_checks++;
        if (position !== e.pos) begin
            n_fail++; $display("FAIL sb_pos t=%0t got %h want %h", $time, position, e.pos);
        end
        n_checks++;
        if (busy !== e.busy) begin
            n_fail++; $display("FAIL sb_busy t=%0t got %b want %b", $time, busy, e.busy);
        end
        n_checks++;
        if (done !== e.done) begin
            n_fail++; $display("FAIL sb_done t=%0t got %b want %b", $time, done, e.done);
        end
        n_checks++;
        if (cmd_ready !== e.ready) begin
            n_fail++; $display("FAIL sb_ready t=%0t got %b want %b", $time, cmd_ready, e.ready);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(0, 2'b00, '0, '0, 0);
    endtask

    // Assert reset at a negedge, check forced values, release at the next negedge.
    task automatic apply_reset();
        rst_n = 0; cmd_valid = 0; abort = 0;
        #1;
        n_checks++;
        if ({A, B, busy, done, cmd_ready} !== 5'b00001 || position !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_vals got A%b B%b busy%b done%b ready%b pos%h want 0 0 0 0 1 0000",
                     A, B, busy, done, cmd_ready, position);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        // first edge after release must not accept
        cycle(1, CW, 16'd1, 16'd1, 0);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL first_edge_accept got busy %b want 0", busy); end
        cycle(1, CW, 16'd1, 16'd1, 0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL second_edge_accept got busy %b want 1", busy); end
        cycle(0, 2'b00, '0, '0, 0);
        cycle(0, 2'b00, '0, '0, 0);
    endtask

    task automatic test_cw();
        logic [1:0] hist [13];
        int unsigned ndone;
        apply_reset();
        idle(1);
        cycle(1, CW, 16'd4, 16'd3, 0);
        hist[0] = obs_ab; ndone = 0;
        for (int unsigned c = 1; c <= 12; c++) begin
            cycle(0, 2'b00, '0, '0, 0);
            hist[c] = obs_ab;
            if (obs_done) ndone++;
        end
        n_checks++;
        if ({hist[2], hist[3], hist[6], hist[9], hist[12]} !== 10'b00_01_11_10_00) begin
            n_fail++;
            $display("FAIL cw_seq got %b %b %b %b %b want 00 01 11 10 00",
                     hist[2], hist[3], hist[6], hist[9], hist[12]);
        end
        n_checks++;
        if (obs_pos !== 16'd4 || obs_done !== 1'b1 || ndone != 1) begin
            n_fail++; $display("FAIL cw_end got pos %h done %b ndone %0d want 0004 1 1", obs_pos, obs_done, ndone);
        end
        idle(1);
    endtask

    task automatic test_ccw();
        logic [1:0] hist [6];
        int unsigned ndone;
        apply_reset();
        idle(1);
        cycle(1, CCW, 16'd5, 16'd1, 0);
        ndone = 0;
        for (int unsigned c = 1; c <= 5; c++) begin
            cycle(0, 2'b00, '0, '0, 0);
            hist[c] = obs_ab;
            if (obs_done) ndone++;
        end
        idle(2);
        n_checks++;
        if ({hist[1], hist[2], hist[3], hist[4], hist[5]} !== 10'b10_11_01_00_10) begin
            n_fail++;
            $display("FAIL ccw_seq got %b %b %b %b %b want 10 11 01 00 10",
                     hist[1], hist[2], hist[3], hist[4], hist[5]);
        end
        n_checks++;
        if (obs_pos !== 16'hFFFB || ndone != 1) begin
            n_fail++; $display("FAIL ccw_end got pos %h ndone %0d want fffb 1", obs_pos, ndone);
        end
    endtask

    task automatic test_degenerate();
        logic [1:0]  ab0, ab1;
        logic [15:0] p0;
        ab0 = obs_ab; p0 = obs_pos;
        cycle(1, BAD, 16'd5, 16'd1, 0);
        n_checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_ab !== ab0) begin
            n_fail++; $display("FAIL dir11 got done %b busy %b ab %b want 1 0 %b", obs_done, obs_busy, obs_ab, ab0);
        end
        cycle(1, CW, 16'd0, 16'd1, 0);
        n_checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_ab !== ab0 || obs_pos !== p0) begin
            n_fail++; $display("FAIL steps0 got done %b busy %b ab %b pos %h", obs_done, obs_busy, obs_ab, obs_pos);
        end
        idle(1);
        cycle(1, CW, 16'd2, 16'd0, 0);
        cycle(0, 2'b00, '0, '0, 0);
        ab1 = obs_ab;
        n_checks++;
        if (ab1 === ab0) begin n_fail++; $display("FAIL period0_first got ab %b want change from %b", ab1, ab0); end
        cycle(0, 2'b00, '0, '0, 0);
        n_checks++;
        if (obs_ab === ab1 || obs_done !== 1'b1 || obs_pos !== p0 + 16'd2) begin
            n_fail++; $display("FAIL period0_second got ab %b done %b pos %h want step done 1 pos %h",
                               obs_ab, obs_done, obs_pos, p0 + 16'd2);
        end
        idle(1);
    endtask

    task automatic test_abort();
        logic [1:0]  ab_hold;
        logic [15:0] p0;
        logic        saw_done;
        cycle(0, 2'b00, '0, '0, 1);     // abort in IDLE has no effect
        p0 = obs_pos;
        cycle(1, CW, 16'd10, 16'd2, 0);
        for (int unsigned c = 1; c <= 4; c++) cycle(0, 2'b00, '0, '0, 0);
        ab_hold = obs_ab;
        cycle(0, 2'b00, '0, '0, 1);
        n_checks++;
        if (obs_busy !== 1'b0 || obs_ab !== ab_hold || obs_pos !== p0 + 16'd2 || obs_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_mid got busy %b ab %b pos %h done %b want 0 %b %h 0",
                               obs_busy, obs_ab, obs_pos, obs_done, ab_hold, p0 + 16'd2);
        end
        saw_done = 0;
        for (int unsigned c = 0; c < 4; c++) begin cycle(0, 2'b00, '0, '0, 0); saw_done |= obs_done; end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone got done %b want 0", saw_done); end
        p0 = obs_pos;
        cycle(1, CW, 16'd3, 16'd1, 0);
        cycle(0, 2'b00, '0, '0, 0);
        cycle(0, 2'b00, '0, '0, 0);
        ab_hold = obs_ab;
        cycle(0, 2'b00, '0, '0, 1);
        n_checks++;
        if (obs_ab !== ab_hold || obs_pos !== p0 + 16'd2 || obs_done !== 1'b0 || obs_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_last got ab %b pos %h done %b busy %b want %b %h 0 0",
                               obs_ab, obs_pos, obs_done, obs_busy, ab_hold, p0 + 16'd2);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ab1;
        logic [15:0] p0;
        p0 = obs_pos;
        cycle(1, CW, 16'd2, 16'd1, 0);
        cycle(1, CCW, 16'd1, 16'd1, 0);  // payload change while busy must be ignored
        ab1 = obs_ab;
        cycle(1, CCW, 16'd1, 16'd1, 0);
        n_checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_pos !== p0 + 16'd2) begin
            n_fail++; $display("FAIL b2b_first got done %b busy %b pos %h want 1 0 %h", obs_done, obs_busy, obs_pos, p0 + 16'd2);
        end
        cycle(1, CCW, 16'd1, 16'd1, 0);
        n_checks++;
        if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", obs_busy); end
        cycle(0, 2'b00, '0, '0, 0);
        n_checks++;
        if (obs_ab !== ab1 || obs_pos !== p0 + 16'd1 || obs_done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second got ab %b pos %h done %b want %b %h 1", obs_ab, obs_pos, obs_done, ab1, p0 + 16'd1);
        end
        idle(1);
    endtask

    task automatic test_reset_during_run();
        cycle(1, CW, 16'd8, 16'd1, 0);
        idle(3);
        apply_reset();
        cycle(1, CW, 16'd1, 16'd1, 0);
        n_checks++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_ab !== 2'b00) begin
            n_fail++; $display("FAIL reset_run got done %b busy %b ab %b want 0 0 00", obs_done, obs_busy, obs_ab);
        end
        idle(2);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_cw();
        test_ccw();
        test_degenerate();
        test_abort();
        test_back_to_back();
        test_reset_during_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
